// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: state encoding and PC constants.
package pc_ctrl_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL,
        FLUSH
    } pc_state_e;

endpackage

// File: rtl/pc_ctrl_if.sv
// Request/command bundle between the writeback/execute/hazard units, pc_ctrl and the PC register.
interface pc_ctrl_if
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic             wr_req;
    logic [PC_W-1:0]  wr_data;
    logic             br_req;
    logic [PC_W-1:0]  br_off;
    logic             stall;
    logic             pc_reset;
    logic             pc_we;
    logic [PC_W-1:0]  pc_wd;
    logic             pc_ib;
    logic [PC_W-1:0]  pc_bv;
    logic             fetch_valid;
    logic             flush;
    logic [PC_W-1:0]  shadow_pc;
    logic [CNT_W-1:0] lost_cycles;

    modport master (
        input  wr_req, wr_data, br_req, br_off, stall,
        output pc_reset, pc_we, pc_wd, pc_ib, pc_bv, fetch_valid, flush,
               shadow_pc, lost_cycles
    );

    modport slave (
        output wr_req, wr_data, br_req, br_off, stall,
        input  pc_reset, pc_we, pc_wd, pc_ib, pc_bv, fetch_valid, flush,
               shadow_pc, lost_cycles
    );

endinterface

// File: rtl/pc_ctrl.sv
// PC command sequencer: arbitrates write/branch/stall/increment, inserts post-redirect
// bubbles, mirrors the PC value and counts lost fetch cycles.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    pc_ctrl_if.master bus
);

    localparam logic [3:0] FD = 4'(FLUSH_DEPTH);

    pc_state_e        state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [PC_W-1:0]  shadow_q, shadow_d;
    logic [CNT_W-1:0] lost_q, lost_d;
    logic             lost_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= BOOT;
            fcnt_q   <= '0;
            shadow_q <= '0;
            lost_q   <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            shadow_q <= shadow_d;
            lost_q   <= lost_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        fcnt_d          = fcnt_q;
        shadow_d        = shadow_q;
        lost_d          = lost_q;
        lost_evt        = 1'b0;
        bus.pc_reset    = 1'b0;
        bus.pc_we       = 1'b0;
        bus.pc_wd       = '0;
        bus.pc_ib       = 1'b0;
        bus.pc_bv       = '0;
        bus.fetch_valid = 1'b0;
        bus.flush       = 1'b0;

        case (state_q)
            BOOT: begin
                bus.pc_reset = 1'b1;
                shadow_d     = '0;
                state_d      = RUN;
            end
            default: begin
                if (bus.wr_req) begin
                    bus.pc_we = 1'b1;
                    bus.pc_wd = bus.wr_data;
                    bus.flush = 1'b1;
                    shadow_d  = bus.wr_data;
                    fcnt_d    = FD;
                    state_d   = FLUSH;
                    lost_evt  = 1'b1;
                end else if (bus.br_req) begin
                    bus.pc_ib = 1'b1;
                    bus.pc_bv = bus.br_off;
                    bus.flush = 1'b1;
                    shadow_d  = shadow_q + bus.br_off;
                    fcnt_d    = FD;
                    state_d   = FLUSH;
                    lost_evt  = 1'b1;
                end else if (state_q == FLUSH) begin
                    // Bubble: rewrite the current PC so the register holds.
                    bus.pc_we = 1'b1;
                    bus.pc_wd = shadow_q;
                    bus.flush = 1'b1;
                    lost_evt  = 1'b1;
                    if (!bus.stall) begin
                        fcnt_d = fcnt_q - 4'd1;
                        if (fcnt_q == 4'd1) begin
                            state_d = RUN;
                        end
                    end
                end else if (bus.stall) begin
                    bus.pc_we = 1'b1;
                    bus.pc_wd = shadow_q;
                    state_d   = STALL;
                    lost_evt  = 1'b1;
                end else begin
                    bus.fetch_valid = 1'b1;
                    shadow_d        = shadow_q + PC_INC;
                    state_d         = RUN;
                end
            end
        endcase

        if (lost_evt && (lost_q != '1)) begin
            lost_d = lost_q + CNT_W'(1);
        end
    end

    assign bus.shadow_pc   = shadow_q;
    assign bus.lost_cycles = lost_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus random requests against a
// cycle-level reference model of PC, remaining bubbles and lost-cycle count.
module tb_pc_ctrl;
    import pc_ctrl_pkg::*;

    localparam int unsigned FD       = 2;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned LOST_MAX = (1 << CNT_W) - 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    pc_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

    pc_ctrl #(
        .FLUSH_DEPTH(FD),
        .CNT_W      (CNT_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if.master)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    bit          m_boot    = 1'b0;
    int unsigned m_bubbles = 0;
    logic [31:0] m_pc      = '0;
    int unsigned m_lost    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] wd, input logic b,
                         input logic [31:0] bo, input logic s);
        bus_if.wr_req  = w;
        bus_if.wr_data = wd;
        bus_if.br_req  = b;
        bus_if.br_off  = bo;
        bus_if.stall   = s;
    endtask

    // One clock cycle: drive shortly after a rising edge, check the combinational
    // command, then check registered state just after the next edge.
    task automatic step(input logic w, input logic [31:0] wd, input logic b,
                        input logic [31:0] bo, input logic s);
        logic        e_rst, e_we, e_ib, e_fv, e_fl;
        logic [31:0] e_wd, e_bv, n_pc;
        bit          lost;
        e_rst = 1'b0; e_we = 1'b0; e_ib = 1'b0; e_fv = 1'b0; e_fl = 1'b0;
        e_wd  = '0;   e_bv = '0;   n_pc = m_pc; lost = 1'b0;
        drive(w, wd, b, bo, s);
        #1;
        if (m_boot) begin
            e_rst = 1'b1;
            n_pc  = '0;
        end else if (w) begin
            e_we = 1'b1; e_wd = wd; e_fl = 1'b1;
            n_pc = wd; m_bubbles = FD; lost = 1'b1;
        end else if (b) begin
            e_ib = 1'b1; e_bv = bo; e_fl = 1'b1;
            n_pc = m_pc + bo; m_bubbles = FD; lost = 1'b1;
        end else if (m_bubbles > 0) begin
            e_we = 1'b1; e_wd = m_pc; e_fl = 1'b1; lost = 1'b1;
            if (!s) m_bubbles--;
        end else if (s) begin
            e_we = 1'b1; e_wd = m_pc; lost = 1'b1;
        end else begin
            e_fv = 1'b1;
            n_pc = m_pc + 32'd4;
        end
        check_eq("pc_reset",    32'(bus_if.pc_reset),    32'(e_rst));
        check_eq("pc_we",       32'(bus_if.pc_we),       32'(e_we));
        check_eq("pc_wd",       bus_if.pc_wd,            e_wd);
        check_eq("pc_ib",       32'(bus_if.pc_ib),       32'(e_ib));
        check_eq("pc_bv",       bus_if.pc_bv,            e_bv);
        check_eq("fetch_valid", 32'(bus_if.fetch_valid), 32'(e_fv));
        check_eq("flush",       32'(bus_if.flush),       32'(e_fl));
        @(posedge clk);
        m_boot = 1'b0;
        m_pc   = n_pc;
        if (lost && m_lost < LOST_MAX) m_lost++;
        #1;
        check_eq("shadow_pc",   bus_if.shadow_pc,        m_pc);
        check_eq("lost_cycles", 32'(bus_if.lost_cycles), 32'(m_lost));
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Asserts reset asynchronously mid-cycle and checks the effect before any edge.
    task automatic apply_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_pc_reset", 32'(bus_if.pc_reset),    32'd1);
        check_eq("rst_flush",    32'(bus_if.flush),       32'd0);
        check_eq("rst_fetch",    32'(bus_if.fetch_valid), 32'd0);
        check_eq("rst_we_ib",    32'({bus_if.pc_we, bus_if.pc_ib}), 32'd0);
        check_eq("rst_shadow",   bus_if.shadow_pc,        32'd0);
        check_eq("rst_lost",     32'(bus_if.lost_cycles), 32'd0);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        m_boot    = 1'b1;
        m_pc      = '0;
        m_lost    = 0;
        m_bubbles = 0;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        apply_reset();

        // Boot cycle ignores a pending write; then sequential fetch up to 0x20.
        step(1'b1, 32'h0000_1234, 1'b1, 32'h8, 1'b1);
        idle(8);
        check_eq("pc_at_0x20", bus_if.shadow_pc, 32'h20);

        // Backward branch, bubbles, resume.
        step(1'b0, '0, 1'b1, 32'hFFFF_FFF0, 1'b0);
        idle(3);
        check_eq("pc_after_br", bus_if.shadow_pc, 32'h14);

        // All three requests together: write wins.
        step(1'b1, 32'h400, 1'b1, 32'h8, 1'b1);
        idle(3);

        // Stall for five cycles at 0x40.
        step(1'b1, 32'h3C, 1'b0, '0, 1'b0);
        idle(3);
        for (int unsigned i = 0; i < 5; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
        idle(1);

        // Branch accepted in the second bubble cycle reloads the bubble count.
        step(1'b0, '0, 1'b1, 32'h100, 1'b0);
        idle(1);
        step(1'b0, '0, 1'b1, 32'h100, 1'b0);
        idle(3);

        // Stall inside a flush freezes the bubble countdown.
        step(1'b0, '0, 1'b1, 32'h20, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        idle(3);

        // PC wrap on increment.
        step(1'b1, 32'hFFFF_FFF8, 1'b0, '0, 1'b0);
        idle(4);

        // Random traffic with occasional resets.
        for (int unsigned i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                step($urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 7) == 0,  $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 3) == 0);
            end
        end

        // Drive the counter into saturation, then reset in the middle of a flush.
        for (int unsigned i = 0; i < LOST_MAX + 20; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("lost_saturated", 32'(bus_if.lost_cycles), LOST_MAX);
        step(1'b0, '0, 1'b1, 32'h40, 1'b0);
        idle(1);
        apply_reset();
        step(1'b0, '0, 1'b0, '0, 1'b0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
